// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_e   : responder FSM state encoding
//   WAIT_CNT_W   : width of the wait-state counter
//   merge_bytes  : byte-lane merge of store data into an existing word
package dm_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dm_state_e;

  // Lane i of the result comes from wdata when be[i] is set, otherwise from old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] word;
    word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
    end
    return word;
  endfunction

endpackage

// File: rtl/dm_wait_counter.sv
// Wait-state down-counter for the data-memory responder.
//   clk_i      : clock, rising edge
//   reset_ni   : synchronous active-low reset, clears the count
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module dm_wait_counter
  import dm_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [WAIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: slave end of the M-stage data-memory request interface.
// Accepts one load/store at a time, waits WAIT_CYC cycles, then holds a response
// until consumed. Optional macro DM_TRACE_EN prints each committed non-error store.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_be, req_pc : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                         : response channel
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2,
  parameter logic [31:0] BASE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam bit          ZeroWait = (WAIT_CYC == 0);
  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      ZeroWait ? '0 : WAIT_CNT_W'(WAIT_CYC - 1);

  if (WAIT_CYC > 15) begin : g_wait_cyc_check
    $error("dm_responder: WAIT_CYC must be in 0..15");
  end

  dm_state_e   state_q, state_d;
  logic        accept, commit, cnt_zero;
  logic        lat_we_q;
  logic [31:0] lat_addr_q, lat_wdata_q, lat_pc_q;
  logic [3:0]  lat_be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [Depth];

  // Zero-wait commits on the accept edge itself, so use the live request there.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, word_off, old_word, merged;
  logic [3:0]  cur_be;
  logic [ADDR_W-1:0] idx;
  logic        err;

  assign accept = (state_q == StIdle) && req_valid;
  assign commit = (accept && ZeroWait) || ((state_q == StWait) && cnt_zero);

  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = lat_we_q;
      cur_addr  = lat_addr_q;
      cur_wdata = lat_wdata_q;
      cur_be    = lat_be_q;
    end
    word_off = (cur_addr - BASE) >> 2;
    idx      = word_off[ADDR_W-1:0];
    err      = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE) || ((word_off >> ADDR_W) != '0);
    old_word = mem_q[idx];
    merged   = merge_bytes(old_word, cur_wdata, cur_be);
  end

  dm_wait_counter u_wait_counter (
    .clk_i      (clk),
    .reset_ni   (reset),
    .load_i     (accept && !ZeroWait),
    .load_val_i (WaitLoad),
    .dec_i      (state_q == StWait),
    .zero_o     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = ZeroWait ? StResp : StWait;
      StWait:  if (cnt_zero)  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      lat_pc_q    <= '0;
    end else if (accept) begin
      lat_we_q    <= req_we;
      lat_addr_q  <= req_addr;
      lat_wdata_q <= req_wdata;
      lat_be_q    <= req_be;
      lat_pc_q    <= req_pc;
    end
  end

  // Commit: memory update and response capture happen on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (commit) begin
      err_q <= err;
      if (err) begin
        rdata_q <= '0;
      end else if (cur_we) begin
        mem_q[idx] <= merged;
        rdata_q    <= '0;
      end else begin
        rdata_q <= old_word;
      end
    end
  end

`ifdef DM_TRACE_EN
  logic [31:0] cur_pc;
  assign cur_pc = (state_q == StIdle) ? req_pc : lat_pc_q;

  always_ff @(posedge clk) begin
    if (reset && commit && !err && cur_we) begin
      $display("@%h: *%h <= %h", cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^lat_pc_q;
`endif

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the slave end of the M-stage data-memory request interface that the pipeline drives.
- Accepts one load/store request at a time via valid/ready, inserts a programmable wait-state delay, then returns a response held until consumed.
- Replaces the single-cycle DM behind a multi-cycle handshake so the hazard unit can stall M on a pending response.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2**ADDR_W 32-bit words.
- WAIT_CYC, 2, wait states between accept and response (0..15).
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 on a rising edge clears the block).
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables, bit i = byte lane i; a load ignores it.
- req_pc  in  32  PC of the issuing instruction, used for trace.
- req_ready  out  1  responder can accept.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester consumes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned or out of range).

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - All memory words cleared to 0.
  - Reset overrides every other event in the same cycle.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid&&req_ready: latch we/addr/wdata/be/pc.
  - Go to WAIT with counter=WAIT_CYC-1, or straight to RESP if WAIT_CYC==0.
- WAIT:
  - req_ready=0.
  - counter decrements each cycle; on counter==0 go to RESP.
- Entry to RESP (the commit edge):
  - Error check: err = (addr[1:0]!=0) || ((addr-BASE)>>2 >= 2**ADDR_W) || (addr<BASE).
  - Store without err: merge wdata into the word, byte lanes selected by be.
  - Load without err: rsp_rdata <= the word.
  - Error: no memory update, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - On rsp_ready: rsp_valid drops next cycle and state returns to IDLE.
  - No accept happens in the same cycle as rsp_ready, so the minimum spacing between accepts is WAIT_CYC+2 cycles.
- Latency:
  - WAIT_CYC==0: accept edge → rsp_valid at the next edge.
  - Otherwise: rsp_valid high WAIT_CYC+1 edges after the accept edge.
- Store data returned: rsp_rdata=0 for stores.
- be==4'b0000 store: legal no-op; responds rsp_err=0.
- Reset during WAIT: request is aborted and memory is untouched.
- Reset during RESP: the commit already happened; the response is dropped.
- req_valid while req_ready=0: ignored; the requester must hold the request.
- Counter is 4 bits and never wraps, because WAIT_CYC ≤ 15 is enforced by a parameter check.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on each committed non-error store, print via $display the line "@%h: *%h <= %h" using req_pc, the word-aligned address, and the merged word.
- Not defined: no simulation output; the RTL is otherwise identical.

Decomposition:
- dm_pkg contents:
  - State enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Byte-lane merge function.
  - Constant WAIT_CNT_W=4.
- One sub-module: dm_wait_counter (load, decrement, zero flag).

Test Plan:
- WAIT_CYC=2, store addr 0x10, data 0xDEADBEEF, be 4'hF, rsp_ready=1 → rsp_valid 3 edges after accept, rsp_err=0. A following load of 0x10 returns 0xDEADBEEF.
- Store 0x11223344 at 0x20, then store be 4'b0010 data 0x0000AA00 → load 0x20 returns 0x1122AA44.
- Load at 0x02 → rsp_err=1, rsp_rdata=0. Store at 0x1000 with ADDR_W=10 → rsp_err=1 and word 0 is unchanged.
- rsp_ready held at 0 for 5 cycles → rsp_valid and data stable throughout, req_ready=0 throughout, a second request is not accepted. After rsp_ready=1, req_ready=1 on the next cycle.
- reset=0 asserted during WAIT of a store to 0x30 → next cycle IDLE, rsp_valid=0, and a load of 0x30 returns 0.
- WAIT_CYC=0, back-to-back loads with rsp_ready=1 → each rsp_valid arrives one edge after its accept, with an accept every 2 cycles.
